// File: rtl/wb_sram_responder.sv
// -----------------------------------------------------------------------------
// wb_sram_responder
//
// Wishbone classic single-port SRAM slave. Decodes a 32-bit byte address to a
// word index, performs byte-lane writes and registered reads, and returns a
// one-cycle ack after WAIT_STATES extra cycles.
//
// Parameters:
//   ADDR_WIDTH  - log2 of memory depth in 32-bit words
//   WAIT_STATES - extra cycles between request sample and ack (0..15)
//   BASE_ADDR   - byte base address, aligned to 2^(ADDR_WIDTH+2)
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   wb_adr_i    - byte address (bits [1:0] ignored)
//   wb_dat_i    - write data
//   wb_dat_o    - registered read data (pre-write word on writes)
//   wb_we_i     - 1 = write
//   wb_sel_i    - byte lane enables
//   wb_cyc_i    - bus cycle valid (also the abort signal while waiting)
//   wb_stb_i    - strobe
//   wb_ack_o    - transfer acknowledge, one-cycle pulse
//   wb_err_o    - error acknowledge, one-cycle pulse
//
// Build option:
//   WBMEM_ERR_EN - when defined, out-of-range accesses pulse wb_err_o instead
//                  of wb_ack_o and leave wb_dat_o unchanged. When undefined,
//                  wb_err_o is tied low and out-of-range accesses ack with
//                  read data 0 and writes ignored.
// -----------------------------------------------------------------------------
module wb_sram_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;

    // Request captured in IDLE, used at the access edge when wait states exist.
    logic [31:0] lat_adr;
    logic [31:0] lat_dat;
    logic        lat_we;
    logic [3:0]  lat_sel;

    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  acc_fire;
    logic [31:0]           acc_adr;
    logic [31:0]           acc_dat;
    logic                  acc_we;
    logic [3:0]            acc_sel;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  mem_we;

    assign req = wb_cyc_i & wb_stb_i;

    // Access edge: with no wait states the access happens on the sampling
    // edge from the live bus; otherwise it happens from the latched request
    // on the edge where the wait counter has run out.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        acc_fire = 1'b0;
        acc_adr  = lat_adr;
        acc_dat  = lat_dat;
        acc_we   = lat_we;
        acc_sel  = lat_sel;
        if (WAIT_STATES == 0) begin
            acc_fire = (state == IDLE) && req;
            acc_adr  = wb_adr_i;
            acc_dat  = wb_dat_i;
            acc_we   = wb_we_i;
            acc_sel  = wb_sel_i;
        end else begin
            acc_fire = (state == WAIT) && wb_cyc_i && (wait_cnt == 4'd0);
        end
    end

    assign in_range = (acc_adr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign idx      = acc_adr[ADDR_WIDTH+1:2];

    // The array has no reset, so block writes explicitly while rst_n is low.
    assign mem_we   = rst_n & acc_fire & acc_we & in_range;

    // Word-offset bits are intentionally ignored.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, acc_adr[1:0]};

    // NOTE: the memory array is deliberately left out of reset; resetting
    // it would prevent mapping onto RAM macros and cost a reset tree for no
    // functional gain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    mem[idx][8*b +: 8] <= acc_dat[8*b +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so the read
    // of mem[idx] below sees the pre-write word (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            lat_adr  <= 32'd0;
            lat_dat  <= 32'd0;
            lat_we   <= 1'b0;
            lat_sel  <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        lat_adr <= wb_adr_i;
                        lat_dat <= wb_dat_i;
                        lat_we  <= wb_we_i;
                        lat_sel <= wb_sel_i;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            wait_cnt <= 4'(WAIT_STATES - 1);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;          // initiator abandoned the cycle
                    end else if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;              // forces a gap between acks
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (acc_fire) begin
`ifdef WBMEM_ERR_EN
                wb_ack_o <= in_range;
                if (in_range) begin
                    wb_dat_o <= mem[idx];
                end
`else
                wb_ack_o <= 1'b1;
                wb_dat_o <= in_range ? mem[idx] : 32'd0;
`endif
            end
        end
    end

`ifdef WBMEM_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err_o <= 1'b0;
        end else begin
            wb_err_o <= acc_fire & ~in_range;
        end
    end
`else
    assign wb_err_o = 1'b0;
`endif

endmodule
